button_step_ctrl: RTL
=====================

BUTTON_STEP_CTRL -- requirements
Module: button_step_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
  CLK_HZ, 50000000, clock frequency in Hz
  DEBOUNCE_MS, 20, debounce window; DB_CYCLES = CLK_HZ/1000*DEBOUNCE_MS
  REPEAT_DELAY_MS, 500, first auto-repeat delay; RD_CYCLES = CLK_HZ/1000*REPEAT_DELAY_MS
  REPEAT_RATE_MS, 100, auto-repeat period; RR_CYCLES = CLK_HZ/1000*REPEAT_RATE_MS
REQ-002 Ports SHALL be, one per line:
  clk  input  1  single system clock, rising-edge
  reset  input  1  asynchronous, active-high reset
  button  input  1  raw pushbutton, active-low, asynchronous to clk
  button_pulse  output  1  one-cycle step strobe per accepted press (and per repeat)
  pressed  output  1  debounced button level, 1 = held
  pulse_count  output  8  count of button_pulse strobes issued
REQ-003 Clocking and reset SHALL be exactly as decided: one clock; reset is asynchronous and active-high.

Function
REQ-004 button SHALL pass through a 2-flop synchronizer; its second-flop output s is the only value the FSM samples.
REQ-005 The FSM SHALL have states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT, with a debounce counter of width $clog2(DB_CYCLES).
REQ-006 IDLE: s=0 -> PRESS_WAIT, counter cleared; else stay.
REQ-007 PRESS_WAIT: s=1 -> IDLE (bounce rejected, no pulse); counter == DB_CYCLES-1 with s=0 -> HELD and button_pulse=1 for exactly one cycle; else counter increments.
REQ-008 HELD: s=1 -> RELEASE_WAIT, counter cleared; else stay.
REQ-009 RELEASE_WAIT: s=0 -> HELD with no pulse; counter == DB_CYCLES-1 with s=1 -> IDLE; else counter increments.
REQ-010 pressed SHALL be 1 in HELD and RELEASE_WAIT, 0 otherwise.
REQ-011 Latency: counting the first clock edge that samples button low as edge 1, button_pulse and pressed SHALL be high after edge DB_CYCLES+3.
REQ-012 Release latency: pressed SHALL fall after edge DB_CYCLES+3, counted from the first edge sampling button high.
REQ-013 button_pulse SHALL be registered, never asserted for two consecutive cycles.
REQ-014 pulse_count SHALL increment by 1 in the cycle button_pulse is high; 255 wraps to 0.
REQ-015 DB_CYCLES < 2 SHALL be rejected at elaboration.

Reset
REQ-016 While reset=1: state IDLE; counters 0; button_pulse=0; pressed=0; pulse_count=0; synchronizer flops 1 (released).
REQ-017 Reset asserted in any state SHALL clear all outputs immediately, without waiting for clk.
REQ-018 A button held across reset deassertion SHALL be treated as a new press: one pulse after full debounce latency (REQ-011).

Configuration
REQ-019 Macro STEP_AUTOREPEAT_EN: when defined, HELD SHALL issue a repeat pulse RD_CYCLES cycles after the entry pulse, then every RR_CYCLES cycles while in HELD; the repeat timer restarts from RD_CYCLES on every HELD entry, including RELEASE_WAIT->HELD; repeat pulses increment pulse_count.
REQ-020 When STEP_AUTOREPEAT_EN is undefined, repeat logic SHALL be absent and each accepted press SHALL yield exactly one pulse.

Verification (CLK_HZ=1000, DEBOUNCE_MS=4 -> DB_CYCLES=4, REPEAT_DELAY_MS=10, REPEAT_RATE_MS=5)
REQ-021 Clean press: button low 20 cycles, then high -> single pulse after edge 7; pressed rises after edge 7 and falls after edge 7 of release; pulse_count=1.
REQ-022 Press bounce: low 2, high 1, low 2, then high -> no pulse, pressed=0, pulse_count=0.
REQ-023 Release bounce: in HELD, high 2 cycles, low 1, then low held -> pressed stays 1, no extra pulse.
REQ-024 Reset mid-operation: reset pulsed in PRESS_WAIT and in HELD -> outputs 0 before next clk edge; button held through release -> one pulse 7 edges later.
REQ-025 Wrap: 256 clean presses -> pulse_count reads 0; 257th -> 1.
REQ-026 Auto-repeat: hold 30 cycles -> macro defined: pulses after edges 7, 17, 22, 27, pulse_count=4; macro undefined: pulse after edge 7 only, pulse_count=1.

Source files
------------

// File: rtl/button_step_ctrl.sv
// Debounced pushbutton step controller: 2-flop synchronizer, debounce FSM, one-cycle step strobe.
// Optional auto-repeat while held is enabled by defining STEP_AUTOREPEAT_EN.
module button_step_ctrl #(
    parameter int unsigned CLK_HZ          = 50000000,
    parameter int unsigned DEBOUNCE_MS     = 20,
    parameter int unsigned REPEAT_DELAY_MS = 500,
    parameter int unsigned REPEAT_RATE_MS  = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button,
    output logic       button_pulse,
    output logic       pressed,
    output logic [7:0] pulse_count
);

    localparam int unsigned DB_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int unsigned RD_CYCLES = CLK_HZ / 1000 * REPEAT_DELAY_MS;
    localparam int unsigned RR_CYCLES = CLK_HZ / 1000 * REPEAT_RATE_MS;
    localparam int unsigned CNT_W     = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);

    // A debounce window under two cycles cannot separate bounce from a press.
    if (DB_CYCLES < 2) begin : g_bad_db
        $error("button_step_ctrl: DB_CYCLES must be at least 2");
    end

    // Repeat timing below two cycles would let strobes abut.
    if (RD_CYCLES < 2 || RR_CYCLES < 2) begin : g_bad_rep
        $error("button_step_ctrl: repeat delay and rate must be at least 2 cycles");
    end

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_e;

    state_e             state_q;
    state_e             state_d;
    logic [1:0]         sync_q;
    logic [1:0]         sync_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               pulse_q;
    logic               pulse_d;
    logic               pressed_q;
    logic               pressed_d;
    logic [7:0]         pulse_count_q;
    logic [7:0]         pulse_count_d;
    logic               s;
    logic               db_done;

`ifdef STEP_AUTOREPEAT_EN
    localparam int unsigned REP_MAX = (RD_CYCLES > RR_CYCLES) ? RD_CYCLES : RR_CYCLES;
    localparam int unsigned REP_W   = $clog2(REP_MAX);

    logic [REP_W-1:0]   rep_q;
    logic [REP_W-1:0]   rep_d;
`endif

    // Button is active-low: s=0 means pushed.
    assign sync_d  = {sync_q[0], button};
    assign s       = sync_q[1];
    assign db_done = (cnt_q == CNT_W'(DB_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!s) begin
                    state_d = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (s) begin
                    state_d = IDLE;
                end else if (db_done) begin
                    state_d = HELD;
                end
            end
            HELD: begin
                if (s) begin
                    state_d = RELEASE_WAIT;
                end
            end
            RELEASE_WAIT: begin
                if (!s) begin
                    state_d = HELD;
                end else if (db_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        pulse_d   = 1'b0;
        pressed_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
`ifdef STEP_AUTOREPEAT_EN
        rep_d     = rep_q;
`endif
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
            end
            PRESS_WAIT: begin
                if (!s) begin
                    if (db_done) begin
                        pulse_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            HELD: begin
                cnt_d = '0;
            end
            RELEASE_WAIT: begin
                if (s && !db_done) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: cnt_d = '0;
        endcase
`ifdef STEP_AUTOREPEAT_EN
        // Every entry into HELD, including a rejected release, restarts the long delay.
        if (state_d == HELD && state_q != HELD) begin
            rep_d = REP_W'(RD_CYCLES - 1);
        end else if (state_q == HELD && !s) begin
            if (rep_q == '0) begin
                pulse_d = 1'b1;
                rep_d   = REP_W'(RR_CYCLES - 1);
            end else begin
                rep_d = rep_q - REP_W'(1);
            end
        end
`endif
        pulse_count_d = pulse_count_q + 8'(pulse_d);
    end

    // Synchronizer resets to released so a held button reads as a fresh press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q        <= 2'b11;
            cnt_q         <= '0;
            pulse_q       <= 1'b0;
            pressed_q     <= 1'b0;
            pulse_count_q <= 8'd0;
        end else begin
            sync_q        <= sync_d;
            cnt_q         <= cnt_d;
            pulse_q       <= pulse_d;
            pressed_q     <= pressed_d;
            pulse_count_q <= pulse_count_d;
        end
    end

`ifdef STEP_AUTOREPEAT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end
`endif

    assign button_pulse = pulse_q;
    assign pressed      = pressed_q;
    assign pulse_count  = pulse_count_q;

endmodule
